mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester and the load/store data requester of the multi-cycle core.
- Arbitrates between the two requesters using round-robin on ties.
- Sequences each transaction through a request/grant/response handshake with the memory, with exactly one transaction outstanding.
- Routes the response back to the owner that issued the request.

Parameters:
AW, 32, address width
DW, 32, data width; byte-enable width is DW/8

Ports:
clk  in  1  system clock; the block uses one clock
rst  in  1  reset; asynchronous, active-low (asserted when 0)
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  fetch accepted; one-cycle pulse
if_rvalid  out  1  fetch data valid; one-cycle pulse
if_rdata  out  DW  fetched instruction word
d_req  in  1  data request; held with its fields until d_gnt
d_we  in  1  1 = store, 0 = load
d_be  in  DW/8  store byte enables
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_gnt  out  1  data request accepted; one-cycle pulse
d_rvalid  out  1  load data valid or store complete; one-cycle pulse
d_rdata  out  DW  load data; 0 for stores
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_be  out  DW/8  memory byte enables
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_gnt  in  1  memory accepted mem_req this cycle
mem_rvalid  in  1  memory response; sent for both reads and writes
mem_rdata  in  DW  memory read data
busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; last_owner=DATA.
  - All outputs and the command/response registers are 0.
  - Any in-flight transaction is dropped; a late mem_rvalid after reset is ignored.
- States: IDLE, REQ, WAIT.
- IDLE arbitration (combinational):
  - Only if_req: fetch wins.
  - Only d_req: data wins.
  - Both: the winner is the owner opposite last_owner; after reset, fetch wins the first tie.
  - Winner's x_gnt=1 this cycle.
  - At the clock edge: latch addr/we/be/wdata into the command registers (fetch forces we=0, be=all-ones, wdata=0); set owner and last_owner; go to REQ.
  - No request: stay in IDLE; all gnt outputs 0.
- REQ:
  - mem_req=1; mem_* are driven from the command registers and stay stable until mem_gnt.
  - mem_gnt=0: stay in REQ.
  - mem_gnt=1 and mem_rvalid=0: go to WAIT.
  - mem_gnt=1 and mem_rvalid=1 (zero-latency memory): capture the response and go to IDLE.
  - mem_rvalid without mem_gnt is ignored.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: capture the response and go to IDLE.
- Response capture (registered):
  - The cycle after capture, the owner's x_rvalid=1 for exactly one cycle.
  - if_rdata/d_rdata hold mem_rdata, except d_rdata=0 for a store.
  - The non-owner's rvalid stays 0.
  - rdata outputs hold their value until the next capture for that owner.
- mem_rvalid arriving in IDLE is ignored.
- gnt and rvalid are never asserted to both requesters in the same cycle.
- Latency:
  - Request accepted (gnt) in cycle 0.
  - mem_req in cycle 1.
  - With mem_gnt and mem_rvalid both in cycle 1, x_rvalid in cycle 2 (minimum).
  - Each extra memory wait cycle adds one cycle.
- Throughput:
  - A new grant is possible in the same cycle x_rvalid is high, because state is already IDLE.
  - Minimum 2 cycles per transaction.
- A requester dropping req before gnt is legal; the request is then never issued.
- busy=1 in REQ and WAIT.

Test Plan:
- Reset, then fetch only: if_req=1, if_addr=0x100; mem_gnt=1 in cycle 1, mem_rvalid=1 with mem_rdata=0x00500093 in cycle 2 -> if_gnt in cycle 0, mem_req/mem_addr=0x100/mem_we=0 in cycle 1, if_rvalid=1 with if_rdata=0x00500093 in cycle 3, d_rvalid stays 0.
- Store: d_req=1, d_we=1, d_be=0xF, d_addr=0x2000, d_wdata=0xDEADBEEF; memory responds immediately -> mem_we=1, mem_wdata=0xDEADBEEF; d_rvalid=1 with d_rdata=0 two cycles after d_gnt.
- Tie fairness: both requesters held continuously for 4 transactions after reset -> grant order IF, D, IF, D; no requester is granted twice in a row.
- Memory stall: mem_gnt held 0 for 3 cycles, then mem_rvalid 2 cycles after mem_gnt -> mem_req and mem_addr stable throughout REQ, busy=1, no new gnt until the response is delivered.
- Stray response: mem_rvalid=1 in IDLE, and mem_rvalid in REQ without mem_gnt -> no rvalid to either requester; state unchanged.
- Reset mid-operation: rst=0 while in WAIT, then mem_rvalid after release -> all outputs 0 immediately, no rvalid pulse, next tie goes to IF.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles every handshake signal around the memory arbiter: the fetch
//   requester, the load/store data requester and the shared memory port.
//
//   Port summary (all signals live inside the interface):
//     if_req/if_addr                     fetch request and its address
//     if_gnt/if_rvalid/if_rdata          fetch grant pulse, response pulse, data
//     d_req/d_we/d_be/d_addr/d_wdata     data request and its command fields
//     d_gnt/d_rvalid/d_rdata             data grant pulse, response pulse, data
//     mem_req/mem_we/mem_be/mem_addr/mem_wdata   command to the memory
//     mem_gnt/mem_rvalid/mem_rdata       memory accept, response, read data
//
//   Modports:
//     master - the arbiter: it serves both requesters and masters the memory.
//     slave  - the environment: the two requesters plus the memory itself.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;

  logic            d_req;
  logic            d_we;
  logic [DW/8-1:0] d_be;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the instruction-fetch requester and the
//   load/store data requester. One transaction is outstanding at a time; ties
//   are broken round-robin, and each response is routed back to the requester
//   that issued it.
//
//   Ports:
//     clk   system clock
//     rst   asynchronous reset, active low
//     bus   all requester and memory handshake signals (mem_arbiter_if.master)
//     busy  high while a transaction is in flight (state REQ or WAIT)
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic          busy
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;

  state_t state;
  state_t state_nx;

  owner_t owner;
  owner_t last_owner;

  logic          cmd_we;
  logic [BW-1:0] cmd_be;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          if_rvalid_q;
  logic [DW-1:0] if_rdata_q;
  logic          d_rvalid_q;
  logic [DW-1:0] d_rdata_q;

  logic grant_f;
  logic grant_d;
  logic capture;
  logic mem_req_c;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. A response is only taken in REQ when it comes together
  // with mem_gnt; a stray mem_rvalid in REQ or IDLE does not move the FSM.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_f || grant_d) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          state_nx = bus.mem_rvalid ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output logic. On a tie the winner is the owner that did not win last
  // time. Grants are also gated by rst so that a request held during reset
  // never sees a grant pulse while the state cannot advance.
  always_comb begin
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    mem_req_c = 1'b0;
    capture   = 1'b0;
    busy      = 1'b0;
    if (state == IDLE && rst) begin
      grant_f = bus.if_req && (!bus.d_req || last_owner == DATA);
      grant_d = bus.d_req && (!bus.if_req || last_owner == FETCH);
    end
    mem_req_c = (state == REQ);
    busy      = (state != IDLE);
    capture   = ((state == REQ) && bus.mem_gnt && bus.mem_rvalid) ||
                ((state == WAIT) && bus.mem_rvalid);
  end

  // Command latch, ownership tracking and response capture. Fetches are
  // always full-word reads, so their write fields are forced rather than
  // taken from the fetch side.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner       <= FETCH;
      last_owner  <= DATA;
      cmd_we      <= 1'b0;
      cmd_be      <= '0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      if (grant_f) begin
        owner      <= FETCH;
        last_owner <= FETCH;
        cmd_we     <= 1'b0;
        cmd_be     <= '1;
        cmd_addr   <= bus.if_addr;
        cmd_wdata  <= '0;
      end else if (grant_d) begin
        owner      <= DATA;
        last_owner <= DATA;
        cmd_we     <= bus.d_we;
        cmd_be     <= bus.d_be;
        cmd_addr   <= bus.d_addr;
        cmd_wdata  <= bus.d_wdata;
      end

      if_rvalid_q <= capture && (owner == FETCH);
      d_rvalid_q  <= capture && (owner == DATA);

      if (capture) begin
        if (owner == FETCH) begin
          if_rdata_q <= bus.mem_rdata;
        end else begin
          d_rdata_q <= cmd_we ? '0 : bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_gnt    = grant_f;
  assign bus.d_gnt     = grant_d;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = cmd_we;
  assign bus.mem_be    = cmd_be;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Stimulus pushes the expected grant owner,
//   memory command and response into queues; a monitor on the falling edge
//   pops and compares whenever the DUT grants, issues an accepted memory
//   command or returns a response. Cycle-exact latency and stability checks
//   are made inline with checkOutput.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } rsp_t;

  // Owner encoding: 0 = fetch, 1 = data.
  logic grant_q[$];
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectGrant(input logic o);
    grant_q.push_back(o);
  endtask

  task automatic expectCmd(input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    cmd_t c;
    c.we = we; c.be = be; c.addr = addr; c.wdata = wdata;
    cmd_q.push_back(c);
  endtask

  task automatic expectRsp(input logic o, input logic [31:0] data);
    rsp_t r;
    r.owner = o; r.data = data;
    rsp_q.push_back(r);
  endtask

  // One call = one clock cycle of input values, driven just after the edge.
  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe,
                               input logic [3:0] dbe, input logic [31:0] daddr,
                               input logic [31:0] dwdata, input logic mg,
                               input logic mrv, input logic [31:0] mrd);
    @(posedge clk);
    #1;
    bus.if_req     = ireq;
    bus.if_addr    = iaddr;
    bus.d_req      = dreq;
    bus.d_we       = dwe;
    bus.d_be       = dbe;
    bus.d_addr     = daddr;
    bus.d_wdata    = dwdata;
    bus.mem_gnt    = mg;
    bus.mem_rvalid = mrv;
    bus.mem_rdata  = mrd;
  endtask

  task automatic applyMem(input logic mg, input logic mrv, input logic [31:0] mrd);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, mg, mrv, mrd);
  endtask

  task automatic clearInputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic o;
    cmd_t c;
    rsp_t r;
    if (rst) begin
      checkOutput("gnt_exclusive", 64'(bus.if_gnt & bus.d_gnt), 64'h0);
      checkOutput("rvalid_exclusive", 64'(bus.if_rvalid & bus.d_rvalid), 64'h0);

      if (bus.if_gnt || bus.d_gnt) begin
        if (grant_q.size() == 0) begin
          checkOutput("gnt_unexpected", 64'({bus.if_gnt, bus.d_gnt}), 64'h0);
        end else begin
          o = grant_q.pop_front();
          checkOutput("gnt_owner", 64'(bus.d_gnt), 64'(o));
        end
      end

      if (bus.mem_req && bus.mem_gnt) begin
        if (cmd_q.size() == 0) begin
          checkOutput("mem_cmd_unexpected", 64'(bus.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          c = cmd_q.pop_front();
          checkOutput("mem_addr", 64'(bus.mem_addr), 64'(c.addr));
          checkOutput("mem_wdata", 64'(bus.mem_wdata), 64'(c.wdata));
          checkOutput("mem_we_be", 64'({bus.mem_we, bus.mem_be}), 64'({c.we, c.be}));
        end
      end

      if (bus.if_rvalid || bus.d_rvalid) begin
        if (rsp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 64'({bus.if_rvalid, bus.d_rvalid}), 64'h0);
        end else begin
          r = rsp_q.pop_front();
          checkOutput("rsp_owner", 64'(bus.d_rvalid), 64'(r.owner));
          checkOutput("rsp_data", 64'(bus.d_rvalid ? bus.d_rdata : bus.if_rdata),
                      64'(r.data));
        end
      end
    end
  end

  // Safety bound: the directed sequence is short, this only fires on a hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of sequence");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clearInputs();
    rst = 1'b0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0000_0040;

    // Reset state, with a request held to show no grant escapes during reset.
    repeat (2) @(negedge clk);
    checkOutput("rst_if_gnt", 64'(bus.if_gnt), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_mem_req", 64'(bus.mem_req), 64'h0);
    checkOutput("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    checkOutput("rst_rvalid", 64'({bus.if_rvalid, bus.d_rvalid}), 64'h0);
    @(posedge clk);
    #1;
    clearInputs();
    rst = 1'b1;

    // Fetch only, one memory wait cycle.
    expectGrant(1'b0);
    expectCmd(1'b0, 4'hF, 32'h100, 32'h0);
    expectRsp(1'b0, 32'h0050_0093);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t1_if_gnt", 64'(bus.if_gnt), 64'h1);
    applyMem(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t1_mem_req", 64'(bus.mem_req), 64'h1);
    checkOutput("t1_mem_addr", 64'(bus.mem_addr), 64'h100);
    checkOutput("t1_mem_we", 64'(bus.mem_we), 64'h0);
    checkOutput("t1_busy", 64'(busy), 64'h1);
    applyMem(1'b0, 1'b1, 32'h0050_0093);
    @(negedge clk);
    checkOutput("t1_if_rvalid_early", 64'(bus.if_rvalid), 64'h0);
    applyMem(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t1_if_rvalid", 64'(bus.if_rvalid), 64'h1);
    checkOutput("t1_if_rdata", 64'(bus.if_rdata), 64'h0050_0093);
    checkOutput("t1_d_rvalid", 64'(bus.d_rvalid), 64'h0);

    // Store with a zero-latency memory; store response data must read 0.
    expectGrant(1'b1);
    expectCmd(1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF);
    expectRsp(1'b1, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t2_d_gnt", 64'(bus.d_gnt), 64'h1);
    applyMem(1'b1, 1'b1, 32'h1234_5678);
    @(negedge clk);
    checkOutput("t2_mem_we", 64'(bus.mem_we), 64'h1);
    checkOutput("t2_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
    applyMem(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t2_d_rvalid", 64'(bus.d_rvalid), 64'h1);
    checkOutput("t2_d_rdata", 64'(bus.d_rdata), 64'h0);
    checkOutput("t2_if_rdata_hold", 64'(bus.if_rdata), 64'h0050_0093);

    // Tie fairness after reset: IF, D, IF, D.
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearInputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expectGrant(k[0]);
      if (k[0]) expectCmd(1'b0, 4'hF, 32'h3000, 32'h0);
      else      expectCmd(1'b0, 4'hF, 32'h200, 32'h0);
      expectRsp(k[0], 32'hA000_0000 + 32'(k));
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h3000, 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t3_if_gnt", 64'(bus.if_gnt), 64'(!k[0]));
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h3000, 32'h0,
                    1'b1, 1'b1, 32'hA000_0000 + 32'(k));
      @(negedge clk);
      checkOutput("t3_no_gnt_in_req", 64'({bus.if_gnt, bus.d_gnt}), 64'h0);
    end
    applyMem(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t3_last_d_rvalid", 64'(bus.d_rvalid), 64'h1);

    // Memory stall: 3 cycles without mem_gnt, response 2 cycles after it.
    expectGrant(1'b0);
    expectCmd(1'b0, 4'hF, 32'h400, 32'h0);
    expectRsp(1'b0, 32'h0BAD_F00D);
    expectGrant(1'b1);
    expectCmd(1'b0, 4'hF, 32'h5000, 32'h0);
    expectRsp(1'b1, 32'h1111_2222);
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t4_if_gnt", 64'(bus.if_gnt), 64'h1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h5000, 32'h0, (i == 3), 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t4_mem_req", 64'(bus.mem_req), 64'h1);
      checkOutput("t4_mem_addr", 64'(bus.mem_addr), 64'h400);
      checkOutput("t4_busy", 64'(busy), 64'h1);
      checkOutput("t4_d_gnt_blocked", 64'(bus.d_gnt), 64'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h5000, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t4_wait_mem_req", 64'(bus.mem_req), 64'h0);
    checkOutput("t4_wait_d_gnt", 64'(bus.d_gnt), 64'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h5000, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D);
    @(negedge clk);
    checkOutput("t4_rsp_busy", 64'(busy), 64'h1);
    checkOutput("t4_rsp_d_gnt", 64'(bus.d_gnt), 64'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h5000, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t4_if_rvalid", 64'(bus.if_rvalid), 64'h1);
    checkOutput("t4_d_gnt_same_cycle", 64'(bus.d_gnt), 64'h1);
    applyMem(1'b1, 1'b1, 32'h1111_2222);
    @(negedge clk);
    checkOutput("t4_d_mem_req", 64'(bus.mem_req), 64'h1);
    applyMem(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t4_d_rdata", 64'(bus.d_rdata), 64'h1111_2222);

    // Stray responses in IDLE and in REQ without mem_gnt.
    applyMem(1'b0, 1'b1, 32'h0000_FFFF);
    @(negedge clk);
    checkOutput("t5_idle_busy", 64'(busy), 64'h0);
    applyMem(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t5_idle_rvalid", 64'({bus.if_rvalid, bus.d_rvalid}), 64'h0);
    checkOutput("t5_idle_busy2", 64'(busy), 64'h0);
    expectGrant(1'b0);
    expectCmd(1'b0, 4'hF, 32'h600, 32'h0);
    expectRsp(1'b0, 32'h0000_600D);
    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t5_if_gnt", 64'(bus.if_gnt), 64'h1);
    applyMem(1'b0, 1'b1, 32'h0000_0BAD);
    @(negedge clk);
    checkOutput("t5_req_mem_req", 64'(bus.mem_req), 64'h1);
    applyMem(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t5_still_req", 64'(bus.mem_req), 64'h1);
    checkOutput("t5_req_rvalid", 64'({bus.if_rvalid, bus.d_rvalid}), 64'h0);
    applyMem(1'b1, 1'b1, 32'h0000_600D);
    applyMem(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t5_if_rdata", 64'(bus.if_rdata), 64'h0000_600D);

    // Reset while in WAIT, then a late response.
    expectGrant(1'b1);
    expectCmd(1'b0, 4'hF, 32'h7000, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h7000, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t6_d_gnt", 64'(bus.d_gnt), 64'h1);
    applyMem(1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("t6_in_wait", 64'(busy), 64'h1);
    rst = 1'b0;
    clearInputs();
    #1;
    checkOutput("t6_rst_busy", 64'(busy), 64'h0);
    checkOutput("t6_rst_mem_req", 64'(bus.mem_req), 64'h0);
    checkOutput("t6_rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    checkOutput("t6_rst_if_rdata", 64'(bus.if_rdata), 64'h0);
    checkOutput("t6_rst_d_rdata", 64'(bus.d_rdata), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyMem(1'b0, 1'b1, 32'h0000_DEAD);
    @(negedge clk);
    checkOutput("t6_late_busy", 64'(busy), 64'h0);
    applyMem(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t6_late_rvalid", 64'({bus.if_rvalid, bus.d_rvalid}), 64'h0);
    expectGrant(1'b0);
    expectCmd(1'b0, 4'hF, 32'h800, 32'h0);
    expectRsp(1'b0, 32'h0000_900D);
    applyStimulus(1'b1, 32'h800, 1'b1, 1'b0, 4'hF, 32'h7004, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t6_tie_if_gnt", 64'(bus.if_gnt), 64'h1);
    applyMem(1'b1, 1'b1, 32'h0000_900D);
    applyMem(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t6_if_rvalid", 64'(bus.if_rvalid), 64'h1);
    applyMem(1'b0, 1'b0, 32'h0);
    @(negedge clk);

    checkOutput("grant_q_drained", 64'(grant_q.size()), 64'h0);
    checkOutput("cmd_q_drained", 64'(cmd_q.size()), 64'h0);
    checkOutput("rsp_q_drained", 64'(rsp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
